// File: rtl/btle_rx_packet_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// btle_rx_pkg
//   Shared definitions for the BTLE receive packet sequencer:
//   - rx_state_e   : packet sequencer states
//   - HEADER_BITS  : PDU header length in bits
//   - CRC_BITS     : CRC length in bits
//   - ADV_ACCESS_ADDR : advertising-channel access address
//   - popcount32() : population count used by the tolerant AA matcher
// -----------------------------------------------------------------------------
package btle_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_HEADER,
        ST_PAYLOAD,
        ST_DONE
    } rx_state_e;

    localparam int unsigned HEADER_BITS     = 16;
    localparam int unsigned CRC_BITS        = 24;
    localparam logic [31:0] ADV_ACCESS_ADDR = 32'h8E89_BED6;

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/btle_rx_packet_ctrl_if.sv
// -----------------------------------------------------------------------------
// btle_rx_packet_ctrl_if
//   Groups the demodulator-facing inputs and the PDU-facing outputs of the
//   receive packet sequencer.
//   master : drives rx_enable/access_address/channel_number/phy_bit/bit_valid,
//            observes aa_hit/pdu_bit/pdu_bit_valid/pdu_length/packet_done/
//            search_timeout/busy
//   slave  : the sequencer side (directions reversed)
// -----------------------------------------------------------------------------
interface btle_rx_packet_ctrl_if;

    logic        rx_enable;
    logic [31:0] access_address;
    logic [5:0]  channel_number;
    logic        phy_bit;
    logic        bit_valid;

    logic        aa_hit;
    logic        pdu_bit;
    logic        pdu_bit_valid;
    logic [7:0]  pdu_length;
    logic        packet_done;
    logic        search_timeout;
    logic        busy;

    modport master (
        output rx_enable, access_address, channel_number, phy_bit, bit_valid,
        input  aa_hit, pdu_bit, pdu_bit_valid, pdu_length, packet_done,
               search_timeout, busy
    );

    modport slave (
        input  rx_enable, access_address, channel_number, phy_bit, bit_valid,
        output aa_hit, pdu_bit, pdu_bit_valid, pdu_length, packet_done,
               search_timeout, busy
    );

endinterface

// File: rtl/btle_whitening_lfsr.sv
// -----------------------------------------------------------------------------
// btle_whitening_lfsr
//   7-bit BTLE data whitening generator (x^7 + x^4 + 1). Shared by RX and TX.
//   Ports:
//     clk, rst   : clock, synchronous active-high reset
//     load_i     : load seed from channel index (w[6:1] = bit-reversed ch, w[0]=1)
//     seed_i[5:0]: channel index
//     advance_i  : step the generator by one bit
//     bit_o      : current whitening bit (w[6])
// -----------------------------------------------------------------------------
module btle_whitening_lfsr (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [5:0] seed_i,
    input  logic       advance_i,
    output logic       bit_o
);

    logic [6:0] w_q, w_d;

    always_comb begin
        w_d = w_q;
        if (load_i) begin
            w_d = {seed_i[0], seed_i[1], seed_i[2], seed_i[3], seed_i[4], seed_i[5], 1'b1};
        end else if (advance_i) begin
            // Feedback from w[6] folds into w[4] and wraps into w[0].
            w_d = {w_q[5], w_q[4], w_q[3] ^ w_q[6], w_q[2], w_q[1], w_q[0], w_q[6]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_q <= '0;
        end else begin
            w_q <= w_d;
        end
    end

    assign bit_o = w_q[6];

endmodule

// File: rtl/btle_rx_packet_ctrl.sv
// -----------------------------------------------------------------------------
// btle_rx_packet_ctrl
//   Packet sequencer behind the GFSK demodulator: searches the bit stream for
//   the access address, de-whitens the PDU header, captures the length and
//   gates header + payload + CRC bits downstream, then reports completion.
//   Ports:
//     clk, rst : 16 MHz clock, synchronous active-high reset
//     bus      : btle_rx_packet_ctrl_if.slave
//                in : rx_enable, access_address[31:0], channel_number[5:0],
//                     phy_bit, bit_valid
//                out: aa_hit, pdu_bit, pdu_bit_valid, pdu_length[7:0],
//                     packet_done, search_timeout, busy
//   Build option:
//     BTLE_RX_AA_TOLERANCE_EN : accept the AA with up to AA_MAX_ERR bit errors;
//                               undefined -> exact 32-bit match.
// -----------------------------------------------------------------------------
module btle_rx_packet_ctrl
    import btle_rx_pkg::*;
#(
    parameter int unsigned CNT_WIDTH      = 12,
    parameter int unsigned SEARCH_TIMEOUT = 0,
    parameter int unsigned AA_MAX_ERR     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    btle_rx_packet_ctrl_if.slave bus
);

    localparam logic [CNT_WIDTH-1:0] HDR_LAST   = CNT_WIDTH'(HEADER_BITS - 1);
    localparam logic [CNT_WIDTH-1:0] LEN_FIRST  = CNT_WIDTH'(8);
    localparam logic [CNT_WIDTH-1:0] FIXED_LAST = CNT_WIDTH'(HEADER_BITS + CRC_BITS - 1);

    rx_state_e            state_q, state_d;
    logic [31:0]          sr_q, sr_d;
    logic [31:0]          aa_q, aa_d;
    logic [31:0]          tcnt_q, tcnt_d;
    logic [5:0]           ch_q, ch_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [7:0]           len_q, len_d;
    logic                 aa_hit_q, aa_hit_d;
    logic                 pdu_bit_q, pdu_bit_d;
    logic                 pdu_vld_q, pdu_vld_d;
    logic                 done_q, done_d;
    logic                 tmo_q, tmo_d;

    logic [31:0]          sr_shift;
    logic [31:0]          tcnt_inc;
    logic [CNT_WIDTH-1:0] last_cnt;
    logic                 accept;
    logic                 aa_match;
    logic                 tmo_hit;
    logic                 in_pdu;
    logic                 lfsr_load;
    logic                 lfsr_adv;
    logic                 w_bit;

    // Match/timeout are judged on the shift register as it will look after
    // the current bit, so a hit is registered on the very bit that completes it.
    always_comb begin
        accept   = bus.bit_valid && bus.rx_enable;
        sr_shift = {bus.phy_bit, sr_q[31:1]};
        tcnt_inc = tcnt_q + 32'd1;
`ifdef BTLE_RX_AA_TOLERANCE_EN
        aa_match = ({26'd0, popcount32(sr_shift ^ aa_q)} <= AA_MAX_ERR);
`else
        aa_match = (sr_shift == aa_q);
`endif
        tmo_hit  = (SEARCH_TIMEOUT != 0) && (tcnt_inc == SEARCH_TIMEOUT);
        last_cnt = FIXED_LAST + (CNT_WIDTH'(len_q) << 3);
    end

`ifndef BTLE_RX_AA_TOLERANCE_EN
    // Error budget only matters for the tolerant matcher.
    logic unused_aa_max_err;
    assign unused_aa_max_err = (AA_MAX_ERR != 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Dropping rx_enable aborts from any active state; a match beats a
    // timeout landing on the same bit.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.rx_enable) state_d = ST_SEARCH;
            end
            ST_SEARCH: begin
                if (!bus.rx_enable) begin
                    state_d = ST_IDLE;
                end else if (bus.bit_valid) begin
                    if (aa_match)     state_d = ST_HEADER;
                    else if (tmo_hit) state_d = ST_IDLE;
                end
            end
            ST_HEADER: begin
                if (!bus.rx_enable) begin
                    state_d = ST_IDLE;
                end else if (bus.bit_valid && (cnt_q == HDR_LAST)) begin
                    state_d = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (!bus.rx_enable) begin
                    state_d = ST_IDLE;
                end else if (bus.bit_valid && (cnt_q == last_cnt)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = bus.rx_enable ? ST_SEARCH : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_pdu    = (state_q == ST_HEADER) || (state_q == ST_PAYLOAD);
        lfsr_load = (state_q == ST_SEARCH) && accept && aa_match;
        lfsr_adv  = in_pdu && accept;

        aa_hit_d  = lfsr_load;
        tmo_d     = (state_q == ST_SEARCH) && accept && !aa_match && tmo_hit;
        done_d    = (state_q == ST_DONE);
        pdu_vld_d = lfsr_adv;
        pdu_bit_d = lfsr_adv ? (bus.phy_bit ^ w_bit) : pdu_bit_q;

        aa_d   = aa_q;
        ch_d   = ch_q;
        sr_d   = sr_q;
        tcnt_d = tcnt_q;
        cnt_d  = cnt_q;
        len_d  = len_q;

        if ((state_q == ST_IDLE) && bus.rx_enable) begin
            aa_d   = bus.access_address;
            ch_d   = bus.channel_number;
            sr_d   = '0;
            tcnt_d = '0;
        end
        // Re-arming after a packet starts a fresh search window.
        if (state_q == ST_DONE) begin
            sr_d   = '0;
            tcnt_d = '0;
        end
        if ((state_q == ST_SEARCH) && accept) begin
            sr_d   = sr_shift;
            tcnt_d = tcnt_inc;
        end

        if (lfsr_load) cnt_d = '0;
        if (lfsr_adv)  cnt_d = cnt_q + CNT_WIDTH'(1);

        // Header bits 8..15 arrive LSB first: shift in from the top.
        if (lfsr_adv && (state_q == ST_HEADER) && (cnt_q >= LEN_FIRST)) begin
            len_d = {bus.phy_bit ^ w_bit, len_q[7:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q      <= '0;
            aa_q      <= '0;
            tcnt_q    <= '0;
            ch_q      <= '0;
            cnt_q     <= '0;
            len_q     <= '0;
            aa_hit_q  <= 1'b0;
            pdu_bit_q <= 1'b0;
            pdu_vld_q <= 1'b0;
            done_q    <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            sr_q      <= sr_d;
            aa_q      <= aa_d;
            tcnt_q    <= tcnt_d;
            ch_q      <= ch_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            aa_hit_q  <= aa_hit_d;
            pdu_bit_q <= pdu_bit_d;
            pdu_vld_q <= pdu_vld_d;
            done_q    <= done_d;
            tmo_q     <= tmo_d;
        end
    end

    btle_whitening_lfsr u_whitening (
        .clk       (clk),
        .rst       (rst),
        .load_i    (lfsr_load),
        .seed_i    (ch_q),
        .advance_i (lfsr_adv),
        .bit_o     (w_bit)
    );

    assign bus.aa_hit         = aa_hit_q;
    assign bus.pdu_bit        = pdu_bit_q;
    assign bus.pdu_bit_valid  = pdu_vld_q;
    assign bus.pdu_length     = len_q;
    assign bus.packet_done    = done_q;
    assign bus.search_timeout = tmo_q;
    assign bus.busy           = in_pdu;

endmodule

// File: tb/tb_btle_rx_packet_ctrl.sv
// -----------------------------------------------------------------------------
// tb_btle_rx_packet_ctrl
//   Self-checking bench for btle_rx_packet_ctrl (SEARCH_TIMEOUT = 100).
//   Packets are built as plain PDU bits, whitened by a reference model and fed
//   to the DUT; the de-whitened stream must reproduce the plain bits.
// -----------------------------------------------------------------------------
module tb_btle_rx_packet_ctrl;
    import btle_rx_pkg::*;

    localparam int TIMEOUT_BITS = 100;
`ifdef BTLE_RX_AA_TOLERANCE_EN
    localparam int TOL = 1;
`else
    localparam int TOL = 0;
`endif

    typedef struct {
        logic [31:0] aa;
        logic [5:0]  ch;
        int          len;
        int          noise;
        logic [31:0] flip;
        int          exp_hit;
        int          exp_nbits;
    } scn_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    btle_rx_packet_ctrl_if bus ();

    btle_rx_packet_ctrl #(
        .CNT_WIDTH      (12),
        .SEARCH_TIMEOUT (TIMEOUT_BITS),
        .AA_MAX_ERR     (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int hit_cnt, done_cnt, to_cnt, to_at_bit, last_vld_cyc, done_cyc, bits_sent;
    bit got_q[$];
    bit exp_q[$];
    bit air_q[$];

    always @(negedge clk) begin
        cyc++;
        if (bus.pdu_bit_valid) begin
            got_q.push_back(bus.pdu_bit);
            last_vld_cyc = cyc;
        end
        if (bus.aa_hit) hit_cnt++;
        if (bus.packet_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.search_timeout) begin
            to_cnt++;
            to_at_bit = bits_sent;
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    function automatic int popcnt(input logic [31:0] v);
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(v[i]);
        return n;
    endfunction

    task automatic clear_mon();
        hit_cnt = 0; done_cnt = 0; to_cnt = 0; to_at_bit = -1;
        last_vld_cyc = -1; done_cyc = -1;
        got_q.delete();
    endtask

    task automatic send_bit(input logic b);
        @(posedge clk); #1;
        bus.phy_bit   = b;
        bus.bit_valid = 1'b1;
        bits_sent++;
        @(posedge clk); #1;
        bus.bit_valid = 1'b0;
        repeat (14) @(posedge clk);
    endtask

    // Plain PDU: random header byte 0, length byte, random payload and CRC.
    // Whitening sequence: rotate the 7-bit register left, and whenever the bit
    // that wrapped round is 1, also flip bit 4.
    task automatic build_pdu(input logic [5:0] ch, input int len);
        int w;
        int n;
        bit p;
        exp_q.delete();
        air_q.delete();
        n = 16 + 8 * len + 24;
        w = 1;
        for (int k = 0; k < 6; k++) w |= int'(ch[k]) << (6 - k);
        for (int i = 0; i < n; i++) begin
            if (i >= 8 && i < 16) p = bit'((len >> (i - 8)) & 1);
            else                  p = bit'($urandom_range(0, 1));
            exp_q.push_back(p);
            air_q.push_back(p ^ bit'((w >> 6) & 1));
            w = ((w << 1) | (w >> 6)) & 'h7f;
            if ((w & 1) != 0) w ^= 'h10;
        end
    endtask

    task automatic arm(input logic [31:0] aa, input logic [5:0] ch);
        clear_mon();
        bus.access_address = aa;
        bus.channel_number = ch;
        @(posedge clk); #1;
        bus.rx_enable = 1'b1;
        repeat (2) @(posedge clk);
        bits_sent = 0;
    endtask

    task automatic disarm();
        @(posedge clk); #1;
        bus.rx_enable = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    function automatic int count_bad(input int n);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            if (i >= got_q.size() || i >= exp_q.size()) bad++;
            else if (got_q[i] != exp_q[i]) bad++;
        end
        return bad;
    endfunction

    task automatic run_scn(input scn_t s, input string tag);
        arm(s.aa, s.ch);
        for (int i = 0; i < s.noise; i++) send_bit(1'($urandom_range(0, 1)));
        for (int i = 0; i < 32; i++) send_bit(s.aa[i] ^ s.flip[i]);
        #1;
        chk({tag, "_busy_after_aa"}, int'(bus.busy), s.exp_hit);
        build_pdu(s.ch, s.len);
        foreach (air_q[i]) send_bit(air_q[i]);
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_aa_hit_count"}, hit_cnt, s.exp_hit);
        chk({tag, "_timeout_count"}, to_cnt, 0);
        chk({tag, "_pdu_bit_count"}, got_q.size(), s.exp_nbits);
        chk({tag, "_packet_done_count"}, done_cnt, s.exp_hit);
        chk({tag, "_busy_end"}, int'(bus.busy), 0);
        if (s.exp_hit != 0) begin
            chk({tag, "_bit_errors"}, count_bad(exp_q.size()), 0);
            chk({tag, "_done_latency"}, done_cyc, last_vld_cyc + 1);
            chk({tag, "_pdu_length"}, int'(bus.pdu_length), s.len);
        end
        disarm();
    endtask

    function automatic int out_vec();
        return int'({bus.aa_hit, bus.pdu_bit, bus.pdu_bit_valid, bus.pdu_length,
                     bus.packet_done, bus.search_timeout, bus.busy});
    endfunction

    scn_t tbl[9];
    scn_t extra;

    initial begin
        tbl[0] = '{ADV_ACCESS_ADDR, 6'd37, 6,   40, 32'h0,         0, 0};
        tbl[1] = '{ADV_ACCESS_ADDR, 6'd37, 0,   10, 32'h0,         0, 0};
        tbl[2] = '{32'h71764129,    6'd9,  255, 5,  32'h0,         0, 0};
        tbl[3] = '{ADV_ACCESS_ADDR, 6'd12, 3,   68, 32'h0,         0, 0};
        tbl[4] = '{ADV_ACCESS_ADDR, 6'd38, 0,   20, 32'h0000_0400, 0, 0};
        tbl[5] = '{ADV_ACCESS_ADDR, 6'd39, 0,   20, 32'h0020_0001, 0, 0};
        for (int i = 6; i < 9; i++) begin
            tbl[i].aa    = $urandom();
            tbl[i].ch    = 6'($urandom_range(0, 39));
            tbl[i].len   = int'($urandom_range(0, 15));
            tbl[i].noise = int'($urandom_range(0, 39));
            tbl[i].flip  = 32'h0;
        end
        foreach (tbl[i]) begin
            tbl[i].exp_hit   = (popcnt(tbl[i].flip) <= TOL) ? 1 : 0;
            tbl[i].exp_nbits = (tbl[i].exp_hit != 0) ? 16 + 8 * tbl[i].len + 24 : 0;
        end

        rst = 1'b1;
        bus.rx_enable = 1'b0;
        bus.access_address = '0;
        bus.channel_number = '0;
        bus.phy_bit = 1'b0;
        bus.bit_valid = 1'b0;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", out_vec(), 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        foreach (tbl[i]) run_scn(tbl[i], $sformatf("scn%0d", i));

        // Noise only: abort on the 100th search bit.
        arm(ADV_ACCESS_ADDR, 6'd1);
        for (int i = 0; i < TIMEOUT_BITS; i++) send_bit(1'($urandom_range(0, 1)));
        repeat (3) @(posedge clk);
        #1;
        chk("timeout_count", to_cnt, 1);
        chk("timeout_at_bit", to_at_bit, TIMEOUT_BITS);
        chk("timeout_no_hit", hit_cnt, 0);
        chk("timeout_busy", int'(bus.busy), 0);
        disarm();

        // rx_enable dropped after 20 payload bits.
        arm(ADV_ACCESS_ADDR, 6'd5);
        for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(0, 1)));
        for (int i = 0; i < 32; i++) send_bit(ADV_ACCESS_ADDR[i]);
        build_pdu(6'd5, 10);
        for (int i = 0; i < 36; i++) send_bit(air_q[i]);
        @(posedge clk); #1;
        bus.rx_enable = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy", int'(bus.busy), 0);
        repeat (40) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt, 0);
        chk("abort_hit", hit_cnt, 1);
        chk("abort_bit_count", got_q.size(), 36);
        chk("abort_bit_errors", count_bad(36), 0);
        extra = '{ADV_ACCESS_ADDR, 6'd37, 4, 12, 32'h0, 1, 16 + 32 + 24};
        run_scn(extra, "after_abort");

        // Synchronous reset in the middle of the header.
        arm(32'hA5C3_0F96, 6'd20);
        for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
        for (int i = 0; i < 32; i++) send_bit(bus.access_address[i]);
        build_pdu(6'd20, 2);
        for (int i = 0; i < 12; i++) send_bit(air_q[i]);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midhdr_reset_outputs", out_vec(), 0);
        rst = 1'b0;
        bus.rx_enable = 1'b0;
        repeat (2) @(posedge clk);
        extra = '{32'h5A3C_F069, 6'd27, 7, 8, 32'h0, 1, 16 + 56 + 24};
        run_scn(extra, "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/btle_rx_packet_ctrl.md
Name: btle_rx_packet_ctrl

Overview:
Packet-level sequencer behind the GFSK demodulator in the BTLE receive chain. It consumes the demodulator's hard-decision bit stream and searches for the access address. On a hit it de-whitens the PDU header, extracts the length, and gates exactly header+payload+CRC bits to the downstream CRC/byte assembler. It then reports completion and re-arms.

Parameters:
CNT_WIDTH, 12, width of the post-AA bit counter; covers a 2080-bit maximum
SEARCH_TIMEOUT, 0, search window in input bits before the search aborts; 0 = never abort
AA_MAX_ERR, 1, maximum AA bit mismatches accepted; used only with the optional feature

Ports:
clk  in  1  system clock, 16 MHz
rst  in  1  synchronous active-high reset
rx_enable  in  1  level; 1 = search/receive permitted
access_address  in  32  expected AA, sampled on IDLE->SEARCH
channel_number  in  6  whitening seed, sampled on IDLE->SEARCH
phy_bit  in  1  demodulated bit
bit_valid  in  1  one-cycle strobe qualifying phy_bit
aa_hit  out  1  one-cycle pulse on AA match
pdu_bit  out  1  de-whitened PDU/CRC bit
pdu_bit_valid  out  1  strobe for pdu_bit
pdu_length  out  8  captured header length byte, held until the next aa_hit
packet_done  out  1  one-cycle pulse after the last CRC bit
search_timeout  out  1  one-cycle pulse on search abort
busy  out  1  high in HEADER or PAYLOAD

Behaviour:
- Reset values: all outputs 0; state = IDLE; AA shift register = 0; counter = 0.
- States:
  - IDLE: on rx_enable=1, latch access_address and channel_number, clear the shift register and timeout count, then go to SEARCH.
  - SEARCH: each bit_valid does sr <= {phy_bit, sr[31:1]} (AA is transmitted LSB first) and increments the timeout count.
  - AA match: the updated sr equals the latched AA. The next cycle pulses aa_hit and enters HEADER, with whitening LFSR loaded and counter = 0.
  - HEADER: 16 bits.
  - PAYLOAD: 8*pdu_length + 24 bits.
  - DONE: one cycle; pulses packet_done; goes to SEARCH if rx_enable else IDLE.
- Timeout: when SEARCH_TIMEOUT != 0 and the count reaches SEARCH_TIMEOUT without a match, pulse search_timeout and return to IDLE. If a match and the timeout occur on the same bit, the match wins.
- Whitening LFSR w[6:0]:
  - Init: w[6:1] = {ch[0],ch[1],ch[2],ch[3],ch[4],ch[5]}, w[0] = 1.
  - Per bit: output bit = w[6]; shift w[k] <= w[k-1] for k != 4; w[4] <= w[3]^w[6]; w[0] <= w[6].
- pdu_bit = phy_bit ^ w[6]; pdu_bit_valid is registered one cycle after bit_valid in HEADER/PAYLOAD.
- Length capture: header bits 8..15 (LSB first) are shifted into pdu_length. It is final on the 16th header bit, and the payload count uses that value (0 allowed -> 24 CRC bits only).
- Counter: increments per accepted bit. HEADER->PAYLOAD when count = 15 on a valid bit. PAYLOAD->DONE when the total post-AA count = 16+8*len+24-1 on a valid bit.
- rx_enable deasserted in any state except IDLE: abort to IDLE on the next cycle. No packet_done; any in-flight pdu_bit_valid still completes.
- bit_valid during the DONE cycle: the bit is ignored. The demodulator delivers bits at most every 16 clk cycles.
- rst mid-packet: immediate return to reset values on the next edge.

Optional Feature:
- Macro: BTLE_RX_AA_TOLERANCE_EN.
- Defined: AA match = popcount(sr ^ AA) <= AA_MAX_ERR, using a combinational popcount.
- Undefined: exact 32-bit equality is required and AA_MAX_ERR is unused.

Decomposition:
- Shared package btle_rx_pkg holds:
  - state encoding constants (IDLE, SEARCH, HEADER, PAYLOAD, DONE);
  - HEADER_BITS = 16, CRC_BITS = 24;
  - the advertising AA constant 0x8E89BED6.
- Sub-module btle_whitening_lfsr (load, seed, advance, out bit) is natural; it will be reused by the TX path.

Test Plan:
- Advertising packet: AA 0x8E89BED6, channel 37, length byte 6 -> aa_hit once; pdu_length = 6; exactly 16+48+24 = 88 pdu_bit_valid; packet_done one cycle after the last one; de-whitened bits match the Python reference.
- Length 0 packet -> 40 pdu_bit_valid then packet_done; length 255 -> 2080 bits, with no counter overflow at CNT_WIDTH = 12.
- SEARCH_TIMEOUT = 100 with noise bits only -> search_timeout at the 100th bit_valid, state IDLE, no aa_hit. With the AA completing on bit 100 -> aa_hit, no timeout.
- AA with one flipped bit -> no hit without BTLE_RX_AA_TOLERANCE_EN; hit with it (AA_MAX_ERR = 1). Two flipped bits -> no hit in either build.
- rx_enable dropped at payload bit 20 -> IDLE next cycle, busy = 0, no packet_done. Re-assert -> a fresh back-to-back packet is received correctly.
- rst pulsed mid-HEADER -> all outputs 0 on the next cycle; a subsequent packet decodes correctly.
